// File: rtl/multistep_shifter_pkg.sv
// -----------------------------------------------------------------------------
// multistep_shifter_pkg
// Shared types and constants for the multi-step shift engine.
//   shift_mode_e : shift operation encoding (matches the 2-bit mode port)
//   state_e      : controller states
//   MODE_*       : raw mode encodings for code that works on plain bit vectors
// -----------------------------------------------------------------------------
package multistep_shifter_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_LSL = 2'b00;
    localparam logic [MODE_W-1:0] MODE_LSR = 2'b01;
    localparam logic [MODE_W-1:0] MODE_ASR = 2'b10;
    localparam logic [MODE_W-1:0] MODE_ROL = 2'b11;

    typedef enum logic [MODE_W-1:0] {
        LSL = MODE_LSL,
        LSR = MODE_LSR,
        ASR = MODE_ASR,
        ROL = MODE_ROL
    } shift_mode_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage : multistep_shifter_pkg

// File: rtl/multistep_shifter_if.sv
// -----------------------------------------------------------------------------
// multistep_shifter_if
// Command/status bundle of the multi-step shifter.
//   load, data        : synchronous load of the shift register (highest priority)
//   start, mode, count: shift request, sampled only when the engine is idle
//   busy, done, q     : engine status and register contents
// Modports: master drives commands, slave (the shifter) drives status.
// -----------------------------------------------------------------------------
interface multistep_shifter_if
    import multistep_shifter_pkg::*;
#(
    parameter int WIDTH = 64
);
    localparam int CNT_W = $clog2(WIDTH);

    logic                load;
    logic [WIDTH-1:0]    data;
    logic                start;
    logic [MODE_W-1:0]   mode;
    logic [CNT_W-1:0]    count;
    logic                busy;
    logic                done;
    logic [WIDTH-1:0]    q;

    modport master (
        output load, data, start, mode, count,
        input  busy, done, q
    );

    modport slave (
        input  load, data, start, mode, count,
        output busy, done, q
    );

endinterface : multistep_shifter_if

// File: rtl/multistep_shifter_step.sv
// -----------------------------------------------------------------------------
// shift_step_unit
// Purely combinational single step of the shift engine.
//   operand_i : value to shift
//   mode_i    : LSL / LSR / ASR / ROL
//   big_i     : 1 = shift by BIG_STEP, 0 = shift by one bit
//   result_o  : shifted value
// Both step sizes are constant, so each path is just wiring plus a mux.
// -----------------------------------------------------------------------------
module shift_step_unit
    import multistep_shifter_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int BIG_STEP = 8
) (
    input  logic [WIDTH-1:0] operand_i,
    input  shift_mode_e      mode_i,
    input  logic             big_i,
    output logic [WIDTH-1:0] result_o
);

    logic             sign_bit;
    logic [WIDTH-1:0] big_res;
    logic [WIDTH-1:0] one_res;

    assign sign_bit = operand_i[WIDTH-1];

    always_comb begin
        big_res = operand_i;
        one_res = operand_i;
        unique case (mode_i)
            LSL: begin
                big_res = {operand_i[WIDTH-BIG_STEP-1:0], {BIG_STEP{1'b0}}};
                one_res = {operand_i[WIDTH-2:0], 1'b0};
            end
            LSR: begin
                big_res = {{BIG_STEP{1'b0}}, operand_i[WIDTH-1:BIG_STEP]};
                one_res = {1'b0, operand_i[WIDTH-1:1]};
            end
            ASR: begin
                big_res = {{BIG_STEP{sign_bit}}, operand_i[WIDTH-1:BIG_STEP]};
                one_res = {sign_bit, operand_i[WIDTH-1:1]};
            end
            ROL: begin
                big_res = {operand_i[WIDTH-BIG_STEP-1:0], operand_i[WIDTH-1:WIDTH-BIG_STEP]};
                one_res = {operand_i[WIDTH-2:0], operand_i[WIDTH-1]};
            end
            default: begin
                big_res = operand_i;
                one_res = operand_i;
            end
        endcase
    end

    assign result_o = big_i ? big_res : one_res;

endmodule : shift_step_unit

// File: rtl/multistep_shifter.sv
// -----------------------------------------------------------------------------
// multistep_shifter
// Iterative shift engine: a shift of any distance 0..WIDTH-1 is executed as
// coarse BIG_STEP steps followed by single-bit steps, one step per cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : multistep_shifter_if.slave (load/data, start/mode/count, busy/done/q)
// load always wins and aborts a shift without a done pulse. done is a
// one-cycle pulse registered on the edge that performs the final step (or on
// the accepting edge for a zero-distance request).
// -----------------------------------------------------------------------------
module multistep_shifter
    import multistep_shifter_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int BIG_STEP = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    multistep_shifter_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [0:0]       ST_IDLE  = IDLE;
    localparam logic [0:0]       ST_SHIFT = SHIFT;
    localparam logic [CNT_W-1:0] BIG_CNT  = CNT_W'(BIG_STEP);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    shift_mode_e      mode_q,  mode_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic             big_step;
    logic [CNT_W-1:0] rem_next;
    logic [WIDTH-1:0] step_res;

    // Take the coarse step whenever at least BIG_STEP bits remain.
    assign big_step = (rem_q >= BIG_CNT);
    assign rem_next = big_step ? (rem_q - BIG_CNT) : (rem_q - ONE_CNT);

    shift_step_unit #(
        .WIDTH    (WIDTH),
        .BIG_STEP (BIG_STEP)
    ) u_step (
        .operand_i (q_q),
        .mode_i    (mode_q),
        .big_i     (big_step),
        .result_o  (step_res)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        q_d     = q_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (bus.load) begin
            // Load aborts any shift in progress; no done is produced.
            q_d     = bus.data;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.count == '0) begin
                            done_d = 1'b1;
                        end else begin
                            mode_d  = shift_mode_e'(bus.mode);
                            rem_d   = bus.count;
                            state_d = ST_SHIFT;
                            busy_d  = 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    q_d   = step_res;
                    rem_d = rem_next;
                    if (rem_next == '0) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            mode_q  <= LSL;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule : multistep_shifter

// File: tb/tb_multistep_shifter.sv
// -----------------------------------------------------------------------------
// tb_multistep_shifter
// Directed, table-driven bench for multistep_shifter (WIDTH=64, BIG_STEP=8),
// plus hand-written sequences for abort, ignored start, back-to-back and reset.
// -----------------------------------------------------------------------------
module tb_multistep_shifter;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  mode;
        logic [5:0]  count;
        logic [63:0] exp_q;
        int          exp_n;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    vec_t vecs [11];

    multistep_shifter_if #(.WIDTH(64)) bus ();

    multistep_shifter #(
        .WIDTH    (64),
        .BIG_STEP (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [63:0] d);
        bus.load = 1'b1;
        bus.data = d;
        tick();
        bus.load = 1'b0;
    endtask

    // Issue start at the current negedge, then count busy cycles until done.
    task automatic run_shift(input string name, input logic [1:0] mode,
                             input logic [5:0] count, input logic [63:0] exp_q,
                             input int exp_n);
        int  nbusy;
        bit  early_done;
        nbusy      = 0;
        early_done = 1'b0;
        bus.start  = 1'b1;
        bus.mode   = mode;
        bus.count  = count;
        tick();
        bus.start  = 1'b0;
        // Scramble the request inputs; the shift in progress must not see them.
        bus.mode   = ~mode;
        bus.count  = 6'd5;
        while (bus.busy === 1'b1 && nbusy < 200) begin
            if (bus.done !== 1'b0) early_done = 1'b1;
            nbusy++;
            tick();
        end
        chk({name, " busy cycles"}, 64'(nbusy), 64'(exp_n));
        chk({name, " done during busy"}, 64'(early_done), 64'd0);
        chk({name, " done pulse"}, 64'(bus.done), 64'd1);
        chk({name, " q"}, bus.q, exp_q);
        tick();
        chk({name, " done cleared"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        bus.load  = 1'b0;
        bus.data  = '0;
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        bus.count = '0;

        vecs[0]  = '{64'h8000_0000_0000_0001, 2'b10, 6'd9,  64'hFFC0_0000_0000_0000, 2};
        vecs[1]  = '{64'h8000_0000_0000_0001, 2'b11, 6'd19, 64'h0000_0000_000C_0000, 5};
        vecs[2]  = '{64'h0000_0000_0000_00FF, 2'b00, 6'd12, 64'h0000_0000_000F_F000, 5};
        vecs[3]  = '{64'h0000_0000_0000_FF00, 2'b01, 6'd8,  64'h0000_0000_0000_00FF, 1};
        vecs[4]  = '{64'h8000_0000_0000_0000, 2'b01, 6'd63, 64'h0000_0000_0000_0001, 14};
        vecs[5]  = '{64'h7000_0000_0000_0000, 2'b10, 6'd4,  64'h0700_0000_0000_0000, 4};
        vecs[6]  = '{64'h0123_4567_89AB_CDEF, 2'b11, 6'd16, 64'h4567_89AB_CDEF_0123, 2};
        vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 6'd63, 64'h8000_0000_0000_0000, 14};
        vecs[8]  = '{64'h8000_0000_0000_0000, 2'b10, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 14};
        vecs[9]  = '{64'h0000_0000_0000_ABCD, 2'b00, 6'd0,  64'h0000_0000_0000_ABCD, 0};
        vecs[10] = '{64'h8000_0000_0000_0001, 2'b11, 6'd1,  64'h0000_0000_0000_0003, 1};

        // Reset state
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset q", bus.q, 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven shifts
        for (int i = 0; i < 11; i++) begin
            do_load(vecs[i].data);
            run_shift($sformatf("vec%0d", i), vecs[i].mode, vecs[i].count,
                      vecs[i].exp_q, vecs[i].exp_n);
        end

        // Abort: load on the third busy cycle
        begin
            bit saw_done;
            saw_done = 1'b0;
            do_load(64'hDEAD_BEEF_0000_0001);
            bus.start = 1'b1; bus.mode = 2'b01; bus.count = 6'd63;
            tick();
            bus.start = 1'b0;
            tick();
            tick();
            chk("abort busy before load", 64'(bus.busy), 64'd1);
            bus.load = 1'b1; bus.data = 64'h1234;
            tick();
            bus.load = 1'b0;
            chk("abort q", bus.q, 64'h1234);
            chk("abort busy", 64'(bus.busy), 64'd0);
            for (int k = 0; k < 20; k++) begin
                if (bus.done !== 1'b0) saw_done = 1'b1;
                tick();
            end
            chk("abort no done", 64'(saw_done), 64'd0);
            chk("abort q held", bus.q, 64'h1234);
        end

        // Ignored start while busy
        do_load(64'hFF00);
        bus.start = 1'b1; bus.mode = 2'b01; bus.count = 6'd8;
        tick();
        bus.mode = 2'b00; bus.count = 6'd5;   // start still high: second request
        chk("ign busy", 64'(bus.busy), 64'd1);
        tick();
        bus.start = 1'b0;
        chk("ign done", 64'(bus.done), 64'd1);
        chk("ign q", bus.q, 64'h00FF);
        tick();
        chk("ign busy after", 64'(bus.busy), 64'd0);
        chk("ign q after", bus.q, 64'h00FF);

        // Back-to-back: new start in the done cycle
        do_load(64'h8000_0000_0000_0001);
        bus.start = 1'b1; bus.mode = 2'b11; bus.count = 6'd1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("b2b first done", 64'(bus.done), 64'd1);
        chk("b2b first q", bus.q, 64'h3);
        bus.start = 1'b1; bus.mode = 2'b11; bus.count = 6'd1;
        tick();
        bus.start = 1'b0;
        chk("b2b second busy", 64'(bus.busy), 64'd1);
        tick();
        chk("b2b second done", 64'(bus.done), 64'd1);
        chk("b2b second q", bus.q, 64'h6);

        // Reset asserted mid-shift
        begin
            bit saw_done;
            saw_done = 1'b0;
            do_load(64'h1);
            bus.start = 1'b1; bus.mode = 2'b00; bus.count = 6'd63;
            tick();
            bus.start = 1'b0;
            tick();
            rst_n = 1'b0;
            #1;
            chk("midrst q", bus.q, 64'd0);
            chk("midrst busy", 64'(bus.busy), 64'd0);
            chk("midrst done", 64'(bus.done), 64'd0);
            tick();
            rst_n = 1'b1;
            for (int k = 0; k < 20; k++) begin
                if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
                tick();
            end
            chk("midrst quiet after release", 64'(saw_done), 64'd0);
            chk("midrst q after release", bus.q, 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_multistep_shifter
